// File: rtl/button_reader_if.sv
// Press-mask handshake bundle between the button reader and the host.
// The master offers out_data/out_valid; the slave answers with out_ready.
interface button_reader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/button_reader.sv
// Button reader: synchronise, debounce, catch presses, and offer the
// accumulated press mask to the host over a valid/ready handshake.
module button_reader #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  btn_raw,
    output logic [WIDTH-1:0]  level,
    output logic              overrun,
    button_reader_if.master   bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt   [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] taken;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;
    state_t           state_q;
    state_t           state_d;

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;

    // Two-flop synchroniser on every raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: accept a new level only after a full run of mismatches.
    always_comb begin
        level_d = level;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2[i] != level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_d[i] = sync2[i];
                end else begin
                    cnt_d[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = level_d & ~level;

    // Debounced levels and their counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            level <= level_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_d[i];
            end
        end
    end

    // Handshake FSM: load the pending mask in IDLE, hold it until accepted.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        taken   = '0;
        unique case (state_q)
            IDLE: begin
                if (|pending) begin
                    taken   = pending;
                    data_d  = pending;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, offered mask, pending presses and the lost-press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            pending <= (pending & ~taken) | press;
            overrun <= |(press & pending & ~taken);
        end
    end
endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with a short debounce window.
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_button_reader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn_raw = 8'hFF;
    logic [7:0] level;
    logic       overrun;
    int         checks = 0;
    int         errors = 0;
    int         ov_cnt;

    button_reader_if #(.WIDTH(8)) bus ();

    button_reader #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_raw),
        .level  (level),
        .overrun(overrun),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n full cycles, ending just after a falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance n cycles counting overrun pulses.
    task automatic step_ov(input int n);
        repeat (n) begin
            @(negedge clk);
            if (overrun) ov_cnt++;
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;

        // 1. reset with all buttons held, then release
        step(3);
        check("rst_level", level, 8'h00);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        step(5);
        check("t1_level_e5", level, 8'h00);
        step(1);
        check("t1_level_e6", level, 8'hFF);
        check("t1_valid_e6", bus.out_valid, 1'b0);
        step(1);
        check("t1_valid_e7", bus.out_valid, 1'b1);
        check("t1_data_e7", bus.out_data, 8'hFF);
        btn_raw = 8'h00;
        bus.out_ready = 1'b1;
        step(1);
        check("t1_hs_valid", bus.out_valid, 1'b0);
        check("t1_hs_data", bus.out_data, 8'hFF);
        bus.out_ready = 1'b0;
        step(10);
        check("t1_rel_level", level, 8'h00);
        check("t1_rel_valid", bus.out_valid, 1'b0);

        // 2. three-cycle glitch on bit0
        btn_raw = 8'h01;
        step(3);
        btn_raw = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("t2_glitch_level", level, 8'h00);
        end
        check("t2_glitch_valid", bus.out_valid, 1'b0);

        // 3. press bit2, hold offer with ready low; 4. press bit1 meanwhile
        btn_raw = 8'h04;
        step(7);
        check("t3_valid", bus.out_valid, 1'b1);
        check("t3_data", bus.out_data, 8'h04);
        btn_raw = 8'h06;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("t3_hold_valid", bus.out_valid, 1'b1);
            check("t3_hold_data", bus.out_data, 8'h04);
        end
        check("t4_level", level, 8'h06);
        bus.out_ready = 1'b1;
        step(1);
        check("t3_hs_valid", bus.out_valid, 1'b0);
        check("t3_hs_data", bus.out_data, 8'h04);
        bus.out_ready = 1'b0;
        step(1);
        check("t4_valid", bus.out_valid, 1'b1);
        check("t4_data", bus.out_data, 8'h02);

        // 5. bit1 re-pressed twice while 8'h02 offered: one overrun
        ov_cnt = 0;
        btn_raw = 8'h04;
        step_ov(8);
        btn_raw = 8'h06;
        step_ov(8);
        check("t5_first_repress", ov_cnt, 0);
        btn_raw = 8'h04;
        step_ov(8);
        btn_raw = 8'h06;
        step_ov(8);
        check("t5_ovr_count", ov_cnt, 1);
        check("t5_data", bus.out_data, 8'h02);
        check("t5_valid", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        step(1);
        check("t5_hs1_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
        step(1);
        check("t5_next_valid", bus.out_valid, 1'b1);
        check("t5_next_data", bus.out_data, 8'h02);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        step(2);
        check("t5_drained", bus.out_valid, 1'b0);

        // 6a. reset mid-debounce
        btn_raw = 8'h00;
        step(3);
        rst_n = 1'b0;
        #1;
        check("t6a_level", level, 8'h00);
        check("t6a_valid", bus.out_valid, 1'b0);
        check("t6a_data", bus.out_data, 8'h00);
        check("t6a_ovr", overrun, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(10);
        check("t6a_post_level", level, 8'h00);
        check("t6a_post_valid", bus.out_valid, 1'b0);

        // 6b. reset during HOLD
        btn_raw = 8'h08;
        step(7);
        check("t6b_valid", bus.out_valid, 1'b1);
        check("t6b_data", bus.out_data, 8'h08);
        rst_n = 1'b0;
        #1;
        check("t6b_rst_valid", bus.out_valid, 1'b0);
        check("t6b_rst_data", bus.out_data, 8'h00);
        check("t6b_rst_level", level, 8'h00);
        btn_raw = 8'h00;
        step(1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step(10);
        check("t6b_post_valid", bus.out_valid, 1'b0);
        check("t6b_post_data", bus.out_data, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
